// File: rtl/spram_stream_ctrl_if.sv
// rtl/spram_stream_ctrl_if.sv - Avalon register window and arithmetic RAM port bundle
interface spram_stream_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 11
);
  logic [2:0]        avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [DATA_W-1:0] avs_writedata;
  logic [DATA_W-1:0] avs_readdata;
  logic              avs_waitrequest;
  logic [ADDR_W-1:0] addr_arith;
  logic [DATA_W-1:0] data_arith;
  logic              we_arith;
  logic [DATA_W-1:0] q_arith;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    output addr_arith, data_arith, we_arith,
    input  avs_readdata, avs_waitrequest, q_arith
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    input  addr_arith, data_arith, we_arith,
    output avs_readdata, avs_waitrequest, q_arith
  );
endinterface

// File: rtl/spram_stream_ctrl.sv
// rtl/spram_stream_ctrl.sv - strided streaming RAM slave with prefetch, stall and clear sweep (SPRAM_CLEAR_EN)
module spram_stream_ctrl #(
  parameter int          DATA_W   = 32,
  parameter int          ADDR_W   = 11,
  parameter logic [31:0] ID_VALUE = 32'h87654321
) (
  input  logic                  clock,
  input  logic                  resetn,
  spram_stream_ctrl_if.slave    bus
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {FILL, READY} pf_state_t;

  pf_state_t         state, state_next;
  logic [DATA_W-1:0] ram [DEPTH];
  logic [DATA_W-1:0] pf_word;
  logic              pf_load;

  logic [ADDR_W-1:0] addr, addr_next;
  logic [ADDR_W-1:0] stride;
  logic [31:0]       count;
  logic              we_bit;
  logic              autoinc;
  logic              col_seen;
  logic [DATA_W-1:0] rd_mux;

  logic              busy;
  logic [ADDR_W-1:0] clr_addr;
  logic              clr_done;

  logic is_data, data_req, ar_we_eff, arith_hit, collision;
  logic acc, wr_acc, rd_acc, data_step, av_ram_wr;

  // Arithmetic writes are suppressed while the clear sweep owns the RAM.
  assign ar_we_eff = bus.we_arith && !busy;
  assign arith_hit = ar_we_eff && (bus.addr_arith == addr);
  assign is_data   = (bus.avs_address == 3'd0);
  assign data_req  = is_data && (bus.avs_read || bus.avs_write);
  // A same-address collision holds the Avalon write for exactly one cycle so the arith write lands first.
  assign collision = is_data && bus.avs_write && arith_hit && !col_seen;
  assign bus.avs_waitrequest = data_req && ((state == FILL) || busy || collision);

  assign acc       = (bus.avs_read || bus.avs_write) && !bus.avs_waitrequest;
  assign wr_acc    = acc && bus.avs_write;
  assign rd_acc    = acc && bus.avs_read && !bus.avs_write;
  assign data_step = acc && is_data;
  assign av_ram_wr = wr_acc && is_data && we_bit;
  assign clr_done  = busy && (&clr_addr);

  // Next pointer: sweep completion, explicit ADDR write, or strided step after a DATA access.
  always_comb begin
    addr_next = addr;
    if (clr_done)
      addr_next = '0;
    else if (wr_acc && (bus.avs_address == 3'd1))
      addr_next = ADDR_W'(bus.avs_writedata);
    else if (data_step && autoinc)
      addr_next = addr + stride;
  end

  // Prefetch next state: any pointer move or RAM write under the pointer forces a refill.
  always_comb begin
    state_next = state;
    pf_load    = 1'b0;
    if (busy || (addr_next != addr) || av_ram_wr) begin
      state_next = FILL;
    end else if (state == FILL) begin
      state_next = READY;
      pf_load    = 1'b1;
    end else if (arith_hit) begin
      state_next = FILL;
    end
  end

  // Prefetch state register; a fill coinciding with an arith write captures the new word directly.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state   <= FILL;
      pf_word <= '0;
    end else begin
      state <= state_next;
      if (pf_load)
        pf_word <= arith_hit ? bus.data_arith : ram[addr];
    end
  end

  // Register readback multiplexer.
  always_comb begin
    rd_mux = '0;
    case (bus.avs_address)
      3'd0:    rd_mux = pf_word;
      3'd1:    rd_mux = DATA_W'(addr);
      3'd2:    rd_mux = DATA_W'({busy, 1'b0, autoinc, we_bit});
      3'd3:    rd_mux = DATA_W'(ID_VALUE);
      3'd4:    rd_mux = DATA_W'(stride);
      3'd5:    rd_mux = DATA_W'(count);
      default: rd_mux = '0;
    endcase
  end

  // Register file, access counter and registered read data.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      addr             <= '0;
      count            <= '0;
      we_bit           <= 1'b0;
      autoinc          <= 1'b1;
      stride           <= ADDR_W'(1);
      col_seen         <= 1'b0;
      bus.avs_readdata <= '0;
    end else begin
      addr     <= addr_next;
      col_seen <= collision;
      if (wr_acc && (bus.avs_address == 3'd1))
        count <= '0;
      else if (data_step)
        count <= count + 32'd1;
      if (wr_acc && (bus.avs_address == 3'd2)) begin
        we_bit  <= bus.avs_writedata[0];
        autoinc <= bus.avs_writedata[1];
      end
      if (wr_acc && (bus.avs_address == 3'd4))
        stride <= ADDR_W'(bus.avs_writedata);
      if (rd_acc)
        bus.avs_readdata <= rd_mux;
    end
  end

`ifdef SPRAM_CLEAR_EN
  // Clear sweep: one zero word per cycle from address 0 to the top, then release.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      busy     <= 1'b0;
      clr_addr <= '0;
    end else if (busy) begin
      clr_addr <= clr_addr + 1'b1;
      if (&clr_addr)
        busy <= 1'b0;
    end else if (wr_acc && (bus.avs_address == 3'd2) && bus.avs_writedata[2]) begin
      busy     <= 1'b1;
      clr_addr <= '0;
    end
  end
`else
  assign busy     = 1'b0;
  assign clr_addr = '0;
`endif

  // RAM array; the Avalon write is ordered after the arith write so it wins on a shared address.
  always_ff @(posedge clock) begin
    if (busy) begin
      ram[clr_addr] <= '0;
    end else begin
      if (ar_we_eff)
        ram[bus.addr_arith] <= bus.data_arith;
      if (av_ram_wr)
        ram[addr] <= bus.avs_writedata;
    end
  end

  // Arithmetic read port: write-first, forced to zero during a sweep.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      bus.q_arith <= '0;
    else if (busy)
      bus.q_arith <= '0;
    else if (bus.we_arith)
      bus.q_arith <= bus.data_arith;
    else
      bus.q_arith <= ram[bus.addr_arith];
  end
endmodule

// File: tb/tb_spram_stream_ctrl.sv
// tb/tb_spram_stream_ctrl.sv - randomized bench for spram_stream_ctrl against a transaction-level model
module tb_spram_stream_ctrl;
  localparam int DW    = 32;
  localparam int AW    = 11;
  localparam int DEPTH = 1 << AW;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  spram_stream_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  spram_stream_ctrl #(.DATA_W(DW), .ADDR_W(AW), .ID_VALUE(32'h87654321)) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [DEPTH];
  int          m_addr, m_stride;
  logic [31:0] m_count, m_rdata;
  logic        m_we, m_autoinc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_addr = 0; m_stride = 1; m_count = 0; m_we = 0; m_autoinc = 1; m_rdata = 0;
  endtask

  task automatic model_step();
    if (m_autoinc) m_addr = (m_addr + m_stride) % DEPTH;
    m_count = m_count + 1;
  endtask

  task automatic model_cmd(input logic [2:0] a, input logic rd, input logic wr, input logic [31:0] wd);
    if (wr) begin
      case (a)
        3'd0: begin if (m_we) mem[m_addr] = wd; model_step(); end
        3'd1: begin m_addr = int'(wd % DEPTH); m_count = 0; end
        3'd2: begin m_we = wd[0]; m_autoinc = wd[1]; end
        3'd4: m_stride = int'(wd % DEPTH);
        default: ;
      endcase
    end else if (rd) begin
      case (a)
        3'd0: begin m_rdata = mem[m_addr]; model_step(); end
        3'd1: m_rdata = m_addr;
        3'd2: m_rdata = {30'd0, m_autoinc, m_we};
        3'd3: m_rdata = 32'h87654321;
        3'd4: m_rdata = m_stride;
        3'd5: m_rdata = m_count;
        default: m_rdata = 0;
      endcase
    end
  endtask

  task automatic av_cmd(input logic [2:0] a, input logic rd, input logic wr, input logic [31:0] wd,
                        input logic ar_en, input logic [AW-1:0] ar_a, input logic [31:0] ar_d,
                        output logic [31:0] rdata, output int stalls);
    int   guard;
    logic done;
    stalls = 0; guard = 0; done = 1'b0;
    bus.avs_address = a; bus.avs_read = rd; bus.avs_write = wr; bus.avs_writedata = wd;
    bus.we_arith = ar_en; bus.addr_arith = ar_a; bus.data_arith = ar_d;
    while (!done) begin
      #1;
      if (!bus.avs_waitrequest) done = 1'b1;
      else if (guard >= 100) begin check("wait_bound", guard, 0); done = 1'b1; end
      else begin stalls++; guard++; @(negedge clock); bus.we_arith = 1'b0; end
    end
    @(posedge clock);
    @(negedge clock);
    bus.avs_read = 1'b0; bus.avs_write = 1'b0; bus.we_arith = 1'b0;
    rdata = bus.avs_readdata;
  endtask

  task automatic cmd(input string tag, input logic [2:0] a, input logic rd, input logic wr,
                     input logic [31:0] wd, output int stalls);
    logic [31:0] got;
    av_cmd(a, rd, wr, wd, 1'b0, '0, '0, got, stalls);
    model_cmd(a, rd, wr, wd);
    check(tag, got, m_rdata);
  endtask

  task automatic ar_op(input logic we, input logic [AW-1:0] a, input logic [31:0] d);
    logic [31:0] exp;
    bus.we_arith = we; bus.addr_arith = a; bus.data_arith = d;
    @(posedge clock);
    @(negedge clock);
    bus.we_arith = 1'b0;
    exp = we ? d : mem[a];
    if (we) mem[a] = d;
    check("q_arith", bus.q_arith, exp);
  endtask

  task automatic do_reset();
    bus.avs_read = 1'b0; bus.avs_write = 1'b0; bus.we_arith = 1'b0;
    resetn = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_waitrequest", 32'(bus.avs_waitrequest), 0);
    check("rst_readdata", bus.avs_readdata, 0);
    check("rst_q_arith", bus.q_arith, 0);
    resetn = 1'b1;
    model_reset();
    @(negedge clock);
  endtask

  int          st;
  logic [31:0] got;

  initial begin
    bus.avs_address = '0; bus.avs_read = 1'b0; bus.avs_write = 1'b0; bus.avs_writedata = '0;
    bus.addr_arith = '0; bus.data_arith = '0; bus.we_arith = 1'b0;
    @(negedge clock);
    do_reset();

    cmd("id", 3'd3, 1, 0, 0, st);
    cmd("stride_rst", 3'd4, 1, 0, 0, st);
    cmd("ctrl_rst", 3'd2, 1, 0, 0, st);
    cmd("addr_rst", 3'd1, 1, 0, 0, st);
    cmd("count_rst", 3'd5, 1, 0, 0, st);
    check("rst_stall", st, 0);

    for (int i = 0; i < DEPTH; i++) ar_op(1'b1, AW'(i), $urandom);

    // burst write with auto-increment
    cmd("t2_addr", 3'd1, 0, 1, 5, st);
    cmd("t2_ctrl", 3'd2, 0, 1, 3, st);
    cmd("t2_w0", 3'd0, 0, 1, 32'hA, st);
    cmd("t2_w1", 3'd0, 0, 1, 32'hB, st);
    cmd("t2_w2", 3'd0, 0, 1, 32'hC, st);
    cmd("t2_addr_rd", 3'd1, 1, 0, 0, st);
    check("t2_addr8", m_rdata, 8);
    cmd("t2_count_rd", 3'd5, 1, 0, 0, st);
    ar_op(1'b0, AW'(6), 0);
    check("t2_q6", bus.q_arith, 32'hB);

    // strided reads, one fill stall each
    cmd("t3_ctrl", 3'd2, 0, 1, 2, st);
    cmd("t3_stride", 3'd4, 0, 1, 2, st);
    cmd("t3_addr", 3'd1, 0, 1, 5, st);
    cmd("t3_r0", 3'd0, 1, 0, 0, st);
    check("t3_r0_val", m_rdata, 32'hA);
    check("t3_r0_stall", st, 1);
    cmd("t3_r1", 3'd0, 1, 0, 0, st);
    check("t3_r1_val", m_rdata, 32'hC);
    check("t3_r1_stall", st, 1);
    cmd("t3_addr_rd", 3'd1, 1, 0, 0, st);
    check("t3_addr9", m_rdata, 9);

    // collision: arith write lands first, Avalon write wins
    cmd("t4_ctrl", 3'd2, 0, 1, 3, st);
    cmd("t4_addr", 3'd1, 0, 1, 4, st);
    av_cmd(3'd0, 1'b0, 1'b1, 32'h1, 1'b1, AW'(4), 32'h2, got, st);
    check("t4_stall", st, 1);
    mem[4] = 32'h2;
    model_cmd(3'd0, 1'b0, 1'b1, 32'h1);
    ar_op(1'b0, AW'(4), 0);
    check("t4_ram4", bus.q_arith, 32'h1);

    // address wrap
    cmd("t5_stride", 3'd4, 0, 1, 3, st);
    cmd("t5_addr", 3'd1, 0, 1, DEPTH - 1, st);
    cmd("t5_rd", 3'd0, 1, 0, 0, st);
    cmd("t5_addr_rd", 3'd1, 1, 0, 0, st);
    check("t5_wrap", m_rdata, 2);

    // read and write together: write wins, readdata held
    cmd("both_rw", 3'd4, 1, 1, 5, st);
    cmd("stride_rd", 3'd4, 1, 0, 0, st);

    // randomized mix of register, DATA and arith traffic
    for (int i = 0; i < 400; i++) begin
      int          k;
      logic [2:0]  a;
      logic [31:0] wd;
      k = int'($urandom_range(0, 9));
      if (k < 3) begin
        ar_op(1'($urandom_range(0, 1)), ($urandom_range(0, 1) == 1) ? AW'(m_addr) : AW'($urandom),
              $urandom);
      end else begin
        a = 3'($urandom);
        case (a)
          3'd1:    wd = $urandom_range(0, DEPTH - 1);
          3'd2:    wd = $urandom_range(0, 3);
          3'd4:    wd = $urandom_range(0, 7);
          default: wd = $urandom;
        endcase
        case ($urandom_range(0, 4))
          0, 1:    cmd("rnd_rd", a, 1, 0, wd, st);
          2, 3:    cmd("rnd_wr", a, 0, 1, wd, st);
          default: cmd("rnd_rw", a, 1, 1, wd, st);
        endcase
      end
    end
    cmd("rnd_count", 3'd5, 1, 0, 0, st);
    cmd("rnd_addr", 3'd1, 1, 0, 0, st);

`ifdef SPRAM_CLEAR_EN
    begin
      int busy_cycles;
      int guard;
      busy_cycles = 0; guard = 0;
      cmd("t6_ctrl", 3'd2, 0, 1, 32'h4 | {30'd0, m_autoinc, m_we}, st);
      got = 32'h8;
      while (got[3] && guard < 5000) begin
        av_cmd(3'd2, 1'b1, 1'b0, 0, 1'b0, '0, '0, got, st);
        if (got[3]) busy_cycles++;
        guard++;
      end
      check("t6_busy_cycles", busy_cycles, DEPTH);
      for (int i = 0; i < DEPTH; i++) mem[i] = 0;
      m_addr = 0;
      cmd("t6_addr0", 3'd1, 1, 0, 0, st);
      cmd("t6_data0", 3'd0, 1, 0, 0, st);
      for (int i = 0; i < 8; i++) ar_op(1'b0, AW'($urandom), 0);
      ar_op(1'b1, AW'(2000), 32'h5A5A);
      cmd("t6_ctrl2", 3'd2, 0, 1, 32'h4 | {30'd0, m_autoinc, m_we}, st);
      repeat (50) @(negedge clock);
      bus.addr_arith = AW'(2000); bus.we_arith = 1'b0;
      @(posedge clock); @(negedge clock);
      check("t6_q_clear", bus.q_arith, 0);
      do_reset();
      cmd("t6_ctrl_after_rst", 3'd2, 1, 0, 0, st);
      ar_op(1'b0, AW'(2000), 0);
    end
`else
    cmd("ctrl_b2_ign", 3'd2, 0, 1, 7, st);
    cmd("ctrl_b2_rd", 3'd2, 1, 0, 0, st);
    check("ctrl_b2_val", m_rdata, 3);
`endif

    // reset after activity restores defaults
    cmd("pre_rst_addr", 3'd1, 0, 1, 77, st);
    do_reset();
    cmd("post_rst_addr", 3'd1, 1, 0, 0, st);
    cmd("post_rst_stride", 3'd4, 1, 0, 0, st);
    cmd("post_rst_ctrl", 3'd2, 1, 0, 0, st);
    cmd("post_rst_count", 3'd5, 1, 0, 0, st);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
